fetch_queue: RTL and testbench

- Instruction-fetch front end. Owns the program counter and issues requests to instruction memory.
- Buffers returned words in a small in-order queue and presents one {PC, instruction} pair per cycle to the IF/ID pipeline register.
- Absorbs variable memory latency, ID-stage stalls and branch/jump redirects, so the decode side sees a clean instruction stream.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_sync_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_queue_pkg;
  localparam int WORD_W      = 32;
  localparam int INSTR_SHIFT = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP = '0;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_ent_t;

  function automatic word_t branch_target(input word_t pc, input word_t off);
    return pc + 32'd4 + (off << INSTR_SHIFT);
  endfunction
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; used for the fetch queue and the
// in-flight request-PC queue. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

  ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
                          (push && full && !pop) |-> flush);
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues imem requests under a credit limit,
// buffers responses and drops stale ones after redirects.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  word_t       branch_offset,
  input  word_t       branch_pc,
  input  logic        jump_taken,
  input  word_t       jump_target,
  output logic        imem_req,
  output word_t       imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  word_t       imem_rdata,
  output word_t       PC,
  output word_t       instruction,
  output logic        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  word_t          fetch_pc_q, fetch_pc_d, target, pcf_rdata;
  logic [CW-1:0]  out_q, out_d, drop_q, drop_d, q_cnt, pcf_cnt;
  logic           redirect, credit_ok, accept, discard;
  logic           q_push, q_pop, q_full, q_empty, pcf_full, pcf_empty;
  fetch_ent_t     q_head, q_wdata;
  logic           unused_flags;

  assign redirect  = branch_taken || jump_taken;
  assign target    = branch_taken ? branch_target(branch_pc, branch_offset) : jump_target;
  assign credit_ok = ({1'b0, q_cnt} + {1'b0, out_q}) < (CW+1)'(DEPTH);

  // Gating with rst keeps the request low while the block is held in reset.
  assign imem_req  = rst && credit_ok && !redirect;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign discard   = imem_rvalid && (drop_q != '0);
  assign q_push    = imem_rvalid && !discard;
  assign q_pop     = inst_valid && !stall && !redirect;

  assign inst_valid  = !q_empty;
  assign PC          = inst_valid ? q_head.pc    : NOP;
  assign instruction = inst_valid ? q_head.instr : NOP;

  assign q_wdata.pc    = pcf_rdata;
  assign q_wdata.instr = imem_rdata;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, imem_rvalid};
    drop_d     = drop_q - {{(CW-1){1'b0}}, discard};
    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect) begin
      fetch_pc_d = target;
      // Everything still in flight is stale, including requests already marked.
      drop_d     = out_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(.WIDTH($bits(word_t)), .DEPTH(DEPTH)) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (accept),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .wdata (fetch_pc_q),
    .rdata (pcf_rdata),
    .full  (pcf_full),
    .empty (pcf_empty),
    .count (pcf_cnt)
  );

  sync_fifo #(.WIDTH($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  assign unused_flags = ^{pcf_full, pcf_cnt, q_full};

  rsp_a: assert property (@(posedge clk) disable iff (!rst) imem_rvalid |-> !pcf_empty);

`ifdef FETCH_PERF_EN
  logic [31:0] bub_q, bub_d, redir_q, redir_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    bub_d      = bub_q;
    redir_d    = redir_q;
    drop_cnt_d = drop_cnt_q;
    if (!inst_valid && !stall && bub_q != '1) bub_d      = bub_q + 32'd1;
    if (redirect && redir_q != '1)            redir_d    = redir_q + 32'd1;
    if (discard && drop_cnt_q != '1)          drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bub_q      <= '0;
      redir_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      bub_q      <= bub_d;
      redir_q    <= redir_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign perf_bubbles   = bub_q;
  assign perf_redirects = redir_q;
  assign perf_dropped   = drop_cnt_q;
`else
  // Default build carries no performance counters.
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against
// an epoch-based model of the fetch stream and an in-order latency memory.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0, rst = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump_taken = 1'b0;
  logic [31:0] branch_offset = '0, branch_pc = '0, jump_target = '0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, PC, instruction;
  logic        inst_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubbles, perf_redirects, perf_dropped;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .branch_pc(branch_pc),
    .jump_taken(jump_taken), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC(PC), .instruction(instruction), .inst_valid(inst_valid)
`ifdef FETCH_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_redirects(perf_redirects), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; int due; int ep; } req_t;
  req_t        pend[$];
  logic [31:0] q[$];
  int          epoch = 0, cyc = 0, last_due = 0, mem_lat = 1, ready_pct = 100;
  logic [31:0] exp_fetch = RESET_PC, stream = RESET_PC;
  int          m_bub = 0, m_redir = 0, m_drop = 0;

  always @(negedge clk) begin
    logic        redir, exp_req, was_valid;
    logic [31:0] tgt;
    req_t        r;
    if (!rst) begin
      pend.delete(); q.delete();
      epoch = 0; cyc = 0; last_due = 0;
      exp_fetch = RESET_PC; stream = RESET_PC;
      m_bub = 0; m_redir = 0; m_drop = 0;
    end else begin
      redir = branch_taken || jump_taken;
      tgt   = branch_taken ? branch_pc + 32'd4 + (branch_offset << 2) : jump_target;
      was_valid = (q.size() != 0);
      n_cmp++;
      if (inst_valid !== was_valid) begin
        n_fail++; $display("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, was_valid);
      end
      n_cmp++;
      if (was_valid && (PC !== q[0] || instruction !== memf(q[0]))) begin
        n_fail++; $display("FAIL mon_head cyc=%0d got=%h/%h exp=%h/%h", cyc, PC, instruction, q[0], memf(q[0]));
      end else if (!was_valid && (PC !== 32'h0 || instruction !== 32'h0)) begin
        n_fail++; $display("FAIL mon_idle cyc=%0d got=%h/%h exp=0/0", cyc, PC, instruction);
      end
      exp_req = ((q.size() + pend.size()) < DEPTH) && !redir;
      n_cmp++;
      if (imem_req !== exp_req) begin
        n_fail++; $display("FAIL mon_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
      end
      if (imem_req) begin
        n_cmp++;
        if (imem_addr !== exp_fetch) begin
          n_fail++; $display("FAIL mon_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_fetch);
        end
      end
`ifdef FETCH_PERF_EN
      n_cmp++;
      if (perf_bubbles !== 32'(m_bub) || perf_redirects !== 32'(m_redir) || perf_dropped !== 32'(m_drop)) begin
        n_fail++; $display("FAIL mon_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc,
                           perf_bubbles, perf_redirects, perf_dropped, m_bub, m_redir, m_drop);
      end
      if (!was_valid && !stall) m_bub++;
      if (redir) m_redir++;
`endif
      // Consumption: each delivered PC must continue the architectural stream.
      if (was_valid && !stall && !redir) begin
        n_cmp++;
        if (q[0] !== stream) begin
          n_fail++; $display("FAIL mon_stream cyc=%0d got=%h exp=%h", cyc, q[0], stream);
        end
        stream = stream + 32'd4;
        void'(q.pop_front());
      end
      if (imem_rvalid && pend.size() != 0) begin
        r = pend.pop_front();
        if (r.ep == epoch) q.push_back(r.addr);
        else m_drop++;
      end
      if (imem_req && imem_ready) begin
        r.addr = exp_fetch;
        r.due  = (cyc + mem_lat > last_due) ? cyc + mem_lat : last_due + 1;
        r.ep   = epoch;
        last_due = r.due;
        pend.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redir) begin
        q.delete(); epoch++;
        exp_fetch = tgt; stream = tgt;
      end
      cyc++;
    end
  end

  // ---------------- memory driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      imem_ready = ($urandom_range(99) < ready_pct);
      if (rst && pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1; imem_rdata = memf(pend[0].addr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
    end
  end

  // ---------------- tasks ----------------
  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump_taken = 1'b0;
    branch_offset = '0; branch_pc = '0; jump_target = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b0; idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    mem_lat = 1; ready_pct = 100;
    @(posedge clk); #2 rst = 1'b0; idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || PC !== 32'h0 || instruction !== 32'h0) begin
      n_fail++; $display("FAIL reset_outs got req=%b v=%b pc=%h ins=%h exp 0", imem_req, inst_valid, PC, instruction);
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_bubbles !== 0 || perf_redirects !== 0 || perf_dropped !== 0) begin
      n_fail++; $display("FAIL reset_perf got %0d/%0d/%0d exp 0", perf_bubbles, perf_redirects, perf_dropped);
    end
`endif
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_first_req got %b/%h exp 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_fill();
    mem_lat = 1; ready_pct = 100;
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_c0 got %b/%h/%b exp 1/0/0", imem_req, imem_addr, inst_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL fill_c1 got valid=%b exp 0", inst_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || PC !== 32'(4*k) || instruction !== memf(32'(4*k))) begin
        n_fail++; $display("FAIL fill_pc%0d got %b/%h/%h exp 1/%h", k, inst_valid, PC, instruction, 32'(4*k));
      end
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1; ready_pct = 100;
    apply_reset();
    stall = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || PC !== 32'h0) begin
      n_fail++; $display("FAIL bp_hold got req=%b v=%b pc=%h exp 0/1/0", imem_req, inst_valid, PC);
    end
    @(posedge clk); #1 stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || PC !== 32'(4*k)) begin
        n_fail++; $display("FAIL bp_drain%0d got %b/%h exp 1/%h", k, inst_valid, PC, 32'(4*k));
      end
    end
  endtask

  task automatic test_branch_inflight();
    mem_lat = 3; ready_pct = 100;
    apply_reset();
    repeat (2) begin @(posedge clk); #1; end
    branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = -32'sd2;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL br_req_low got %b exp 0", imem_req); end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0C) begin
      n_fail++; $display("FAIL br_target got %b/%h exp 1/0000000c", imem_req, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL br_drop%0d got valid=%b pc=%h exp 0", k, inst_valid, PC); end
    end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || PC !== 32'h0C || instruction !== memf(32'h0C)) begin
      n_fail++; $display("FAIL br_first got %b/%h/%h exp 1/0000000c", inst_valid, PC, instruction);
    end
  endtask

  task automatic test_priority_wrap();
    bit seen;
    mem_lat = 1; ready_pct = 100;
    apply_reset();
    branch_taken = 1'b1; jump_taken = 1'b1;
    jump_target = 32'h100; branch_pc = 32'h20; branch_offset = 32'd1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL prio_req_low got %b exp 0", imem_req); end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h28) begin
      n_fail++; $display("FAIL prio_target got %b/%h exp 1/00000028", imem_req, imem_addr);
    end
    repeat (3) begin @(posedge clk); #1; end
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFF8;
    @(posedge clk); #1 idle_inputs();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || PC !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL wrap_first got seen=%b pc=%h exp fffffff8", seen, PC);
    end
    @(negedge clk);
    n_cmp++;
    if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_second got %h exp fffffffc", PC); end
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || PC !== 32'h0) begin n_fail++; $display("FAIL wrap_third got %b/%h exp 1/0", inst_valid, PC); end
  endtask

  task automatic test_async_reset();
    mem_lat = 2; ready_pct = 100;
    apply_reset();
    stall = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || PC !== 32'h0) begin
      n_fail++; $display("FAIL ar_before got %b/%h exp 1/0", inst_valid, PC);
    end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || PC !== 32'h0 || instruction !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL ar_during got v=%b pc=%h ins=%h req=%b exp 0", inst_valid, PC, instruction, imem_req);
    end
    @(posedge clk); #2 stall = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL ar_restart got %b/%h exp 1/%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    ready_pct = 75;
    for (int seg = 0; seg < 3; seg++) begin
      mem_lat = 1 + seg + $urandom_range(1);
      for (int c = 0; c < 300; c++) begin
        @(posedge clk); #1;
        idle_inputs();
        stall = ($urandom_range(3) == 0);
        r = $urandom_range(15);
        if (r <= 2) begin
          branch_taken  = (r != 1);
          jump_taken    = (r != 0);
          branch_pc     = inst_valid ? PC : {$urandom_range(255), 2'b00};
          branch_offset = 32'($urandom_range(64)) - 32'd32;
          jump_target   = {$urandom, 2'b00};
        end
      end
    end
    @(posedge clk); #1 idle_inputs();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_branch_inflight();
    test_priority_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
